id_remap_table_mc: RTL

- Multi-port successor to the single-port ID allocate/restore unit in the AXI reorder path.
- Maps an incoming original transaction ID to a unique ID {row, col}.
- All outstanding transactions of one original ID share a row, so per-ID ordering is preserved downstream.
- Accepts NUM_FREE_PORTS independent completions per cycle (e.g. R and B channels) and returns the original ID one cycle later with a validity check.

---
 rtl/id_remap_pkg.sv | 34 +++
 rtl/id_remap_prio_enc.sv | 23 ++
 rtl/id_remap_table_mc.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/id_remap_pkg.sv
// id_remap shared types and helpers.
// Unique-ID field layout and pack/unpack.
package id_remap_pkg;

  localparam int MAX_W    = 8;
  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;
  localparam int ROW_W    = $clog2(DEF_ROWS);
  localparam int COL_W    = $clog2(DEF_COLS);
  localparam int OCC_W    = $clog2(DEF_ROWS * DEF_COLS) + 1;

  typedef logic [2*MAX_W-1:0] uid_raw_t;

  typedef struct packed {
    logic [MAX_W-1:0] row;
    logic [MAX_W-1:0] col;
  } uid_fields_t;

  function automatic uid_raw_t pack_uid(uid_fields_t f, int col_w);
    uid_raw_t mask;
    mask = (uid_raw_t'(1) << col_w) - uid_raw_t'(1);
    return (uid_raw_t'(f.row) << col_w) | (uid_raw_t'(f.col) & mask);
  endfunction

  function automatic uid_fields_t unpack_uid(uid_raw_t uid, int col_w);
    uid_fields_t f;
    uid_raw_t    mask;
    mask  = (uid_raw_t'(1) << col_w) - uid_raw_t'(1);
    f.row = MAX_W'(uid >> col_w);
    f.col = MAX_W'(uid & mask);
    return f;
  endfunction

endpackage

// File: rtl/id_remap_prio_enc.sv
// Lowest-index set-bit finder.
// found_o is the OR of all requests.
module id_remap_prio_enc
  import id_remap_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // scan high to low so the lowest set bit wins
  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/id_remap_table_mc.sv
// Multi-port ID remap table: rows bind an original ID,
// columns hold its outstanding transactions.
module id_remap_table_mc
  import id_remap_pkg::*;
#(
  parameter  int IN_ID_WIDTH    = 4,
  parameter  int NUM_ROWS       = DEF_ROWS,
  parameter  int NUM_COLS       = DEF_COLS,
  parameter  int OUT_ID_WIDTH   = ROW_W + COL_W,
  parameter  int NUM_FREE_PORTS = 2,
  localparam int RW  = $clog2(NUM_ROWS),
  localparam int CW  = $clog2(NUM_COLS),
  localparam int NS  = NUM_ROWS * NUM_COLS,
  localparam int OW  = $clog2(NS) + 1,
  localparam int P   = NUM_FREE_PORTS,
  localparam int DIW = (P > 1) ? $clog2(P) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_valid,
  input  logic [IN_ID_WIDTH-1:0]          alloc_orig_id,
  output logic                            alloc_ready,
  output logic [OUT_ID_WIDTH-1:0]         alloc_uid,
  input  logic [P-1:0]                    free_valid,
  input  logic [P-1:0][OUT_ID_WIDTH-1:0]  free_uid,
  output logic [P-1:0]                    rest_valid,
  output logic [P-1:0][IN_ID_WIDTH-1:0]   rest_orig_id,
  output logic [P-1:0]                    rest_err,
  output logic [OW-1:0]                   occupancy,
  output logic                            full,
  output logic                            empty
);

  if (OUT_ID_WIDTH < RW + CW) begin : g_bad_uid_w
    $error("OUT_ID_WIDTH narrower than row+col fields");
  end
  if (P < 1 || P > 4) begin : g_bad_ports
    $error("NUM_FREE_PORTS must be 1..4");
  end

  localparam logic [CW:0]   CNT_ONE = (CW + 1)'(1);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);

  logic [NUM_COLS-1:0]    slot_v_q  [NUM_ROWS];
  logic [NUM_COLS-1:0]    slot_v_d  [NUM_ROWS];
  logic [IN_ID_WIDTH-1:0] slot_id_q [NUM_ROWS][NUM_COLS];
  logic [IN_ID_WIDTH-1:0] slot_id_d [NUM_ROWS][NUM_COLS];
  logic [NUM_ROWS-1:0]    bound_q, bound_d;
  logic [IN_ID_WIDTH-1:0] bid_q [NUM_ROWS];
  logic [IN_ID_WIDTH-1:0] bid_d [NUM_ROWS];
  logic [CW:0]            cnt_q [NUM_ROWS];
  logic [CW:0]            cnt_d [NUM_ROWS];
  logic [OW-1:0]          occ_q, occ_d;
  logic [P-1:0]           rv_q, rv_d, re_q, re_d;
  logic [P-1:0][IN_ID_WIDTH-1:0] rid_q, rid_d;

  logic [NUM_ROWS-1:0] hit_vec;
  logic                hit_any, unb_any, col_any;
  logic [RW-1:0]       hit_row, unb_row, sel_row;
  logic [CW-1:0]       sel_col;
  logic                alloc_fire;
  uid_fields_t         a_fld;
  uid_raw_t            a_raw;
  logic                unused_araw;

  logic [RW-1:0] f_row [P];
  logic [CW-1:0] f_col [P];
  logic [P-1:0]  ok;

  // rows already bound to the requested ID
  always_comb begin
    hit_vec = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      hit_vec[r] = bound_q[r] && (bid_q[r] == alloc_orig_id);
  end

  id_remap_prio_enc #(.N(NUM_ROWS)) u_hit_enc (
    .req_i(hit_vec), .found_o(hit_any), .idx_o(hit_row)
  );

  id_remap_prio_enc #(.N(NUM_ROWS)) u_unb_enc (
    .req_i(~bound_q), .found_o(unb_any), .idx_o(unb_row)
  );

  assign sel_row = hit_any ? hit_row : unb_row;

  id_remap_prio_enc #(.N(NUM_COLS)) u_col_enc (
    .req_i(~slot_v_q[sel_row]), .found_o(col_any), .idx_o(sel_col)
  );

  assign alloc_ready = alloc_valid && (hit_any || unb_any) && col_any;
  assign alloc_fire  = alloc_ready;

  // build the zero-extended {row, col} unique ID
  always_comb begin
    a_fld     = '0;
    a_fld.row = MAX_W'(sel_row);
    a_fld.col = MAX_W'(sel_col);
    a_raw     = pack_uid(a_fld, CW);
  end

  assign alloc_uid   = a_raw[OUT_ID_WIDTH-1:0];
  assign unused_araw = ^a_raw[2*MAX_W-1:OUT_ID_WIDTH];

  for (genvar p = 0; p < P; p++) begin : g_port
    uid_fields_t    fld;
    logic [P-1:0]   same;
    logic           dup;
    logic           unused_fld;
    logic [DIW-1:0] unused_dup_idx;

    // decode row/col, ignoring upper uid bits
    always_comb fld = unpack_uid(uid_raw_t'(free_uid[p]), CW);

    assign f_row[p]   = fld.row[RW-1:0];
    assign f_col[p]   = fld.col[CW-1:0];
    assign unused_fld = ^{fld.row[MAX_W-1:RW], fld.col[MAX_W-1:CW]};

    // lower ports freeing the same slot this cycle
    always_comb begin
      same = '0;
      for (int q = 0; q < p; q++)
        same[q] = free_valid[q] && (f_row[q] == f_row[p])
                  && (f_col[q] == f_col[p]);
    end

    id_remap_prio_enc #(.N(P)) u_dup_enc (
      .req_i(same), .found_o(dup), .idx_o(unused_dup_idx)
    );

    assign ok[p] = free_valid[p] && slot_v_q[f_row[p]][f_col[p]] && !dup;
  end

  // table next state: frees clear, alloc sets, rows rebind on count
  always_comb begin
    slot_v_d  = slot_v_q;
    slot_id_d = slot_id_q;
    cnt_d     = cnt_q;
    bid_d     = bid_q;
    bound_d   = '0;
    occ_d     = occ_q;
    for (int p = 0; p < P; p++) begin
      if (ok[p]) begin
        slot_v_d[f_row[p]][f_col[p]] = 1'b0;
        cnt_d[f_row[p]] = cnt_d[f_row[p]] - CNT_ONE;
        occ_d = occ_d - OCC_ONE;
      end
    end
    if (alloc_fire) begin
      slot_v_d[sel_row][sel_col]  = 1'b1;
      slot_id_d[sel_row][sel_col] = alloc_orig_id;
      cnt_d[sel_row] = cnt_d[sel_row] + CNT_ONE;
      occ_d = occ_d + OCC_ONE;
      if (!bound_q[sel_row]) bid_d[sel_row] = alloc_orig_id;
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      bound_d[r] = (cnt_d[r] != '0);
      if (!bound_d[r]) bid_d[r] = '0;
    end
  end

  // restore results, read before the clear
  always_comb begin
    rv_d  = free_valid;
    re_d  = '0;
    rid_d = '0;
    for (int p = 0; p < P; p++) begin
      if (free_valid[p]) begin
        re_d[p] = !ok[p];
        if (ok[p]) rid_d[p] = slot_id_q[f_row[p]][f_col[p]];
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        slot_v_q[r] <= '0;
        bid_q[r]    <= '0;
        cnt_q[r]    <= '0;
        for (int c = 0; c < NUM_COLS; c++) slot_id_q[r][c] <= '0;
      end
      bound_q <= '0;
      occ_q   <= '0;
      rv_q    <= '0;
      re_q    <= '0;
      rid_q   <= '0;
    end else begin
      slot_v_q  <= slot_v_d;
      slot_id_q <= slot_id_d;
      bid_q     <= bid_d;
      cnt_q     <= cnt_d;
      bound_q   <= bound_d;
      occ_q     <= occ_d;
      rv_q      <= rv_d;
      re_q      <= re_d;
      rid_q     <= rid_d;
    end
  end

  assign rest_valid   = rv_q;
  assign rest_err     = re_q;
  assign rest_orig_id = rid_q;
  assign occupancy    = occ_q;
  assign full         = (occ_q == OW'(NS));
  assign empty        = (occ_q == '0);

endmodule
